// File: rtl/enc_8b10b_pkg.sv
// enc_8b10b_pkg: 8b/10b code tables and K-code lookup shared by the encoder.
// Codes are written in transmission order: MSB = a (6b) or f (4b).
package enc_8b10b_pkg;

   localparam int BYTE_W = 8;
   localparam int SYM_W  = 10;

   // 5b/6b: {RD- code, RD+ code}
   localparam logic [11:0] T6 [32] = '{
      12'b100111_011000, 12'b011101_100010, 12'b101101_010010, 12'b110001_110001,
      12'b110101_001010, 12'b101001_101001, 12'b011001_011001, 12'b111000_000111,
      12'b111001_000110, 12'b100101_100101, 12'b010101_010101, 12'b110100_110100,
      12'b001101_001101, 12'b101100_101100, 12'b011100_011100, 12'b010111_101000,
      12'b011011_100100, 12'b100011_100011, 12'b010011_010011, 12'b110010_110010,
      12'b001011_001011, 12'b101010_101010, 12'b011010_011010, 12'b111010_000101,
      12'b110011_001100, 12'b100110_100110, 12'b010110_010110, 12'b110110_001001,
      12'b001110_001110, 12'b101110_010001, 12'b011110_100001, 12'b101011_010100
   };

   // 3b/4b data: {RD- code, RD+ code}; entry 7 is the primary P7 form
   localparam logic [7:0] T4 [8] = '{
      8'b1011_0100, 8'b1001_1001, 8'b0101_0101, 8'b1100_0011,
      8'b1101_0010, 8'b1010_1010, 8'b0110_0110, 8'b1110_0001
   };

   // alternate x.7 form
   localparam logic [7:0] A7_4B = 8'b0111_1000;

   // 3b/4b for K codes, selected by RD after the 6b sub-block
   localparam logic [7:0] TK4 [8] = '{
      8'b1011_0100, 8'b0110_1001, 8'b1010_0101, 8'b1100_0011,
      8'b1101_0010, 8'b0101_1010, 8'b1001_0110, 8'b0111_1000
   };

   localparam logic [11:0] K28_6B = 12'b001111_110000;

   function automatic logic k_supported(input logic [7:0] b);
      return (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) ||
             (b == 8'hFD) || (b == 8'hFE);
   endfunction

endpackage

// File: rtl/enc_8b10b_lane.sv
// enc_8b10b_lane: combinational single-byte 8b/10b encoder with RD in/out.
// Ports: byte_in/k_in/rd_in -> symbol (a = bit 0, f = bit 6), rd_out, k_err.
module enc_8b10b_lane
   import enc_8b10b_pkg::*;
(
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              k_in,
   input  logic              rd_in,
   output logic [SYM_W-1:0]  symbol,
   output logic              rd_out,
   output logic              k_err
);

   logic [4:0]  x;
   logic [2:0]  y;
   logic        k_ok;
   logic        use_a7;
   logic        rd_mid;
   logic [11:0] pair6;
   logic [7:0]  pair4;
   logic [5:0]  c6;
   logic [3:0]  c4;

   always_comb begin
      x      = byte_in[4:0];
      y      = byte_in[7:5];
      k_ok   = k_in && k_supported(byte_in);
      k_err  = k_in && !k_ok;
      pair6  = (k_ok && x == 5'd28) ? K28_6B : T6[x];
      c6     = rd_in ? pair6[5:0] : pair6[11:6];
      // D.7 is balanced yet RD-selected, so flip only on unbalanced codes
      rd_mid = rd_in ^ ($countones(c6) != 3);
      use_a7 = rd_mid ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                      : (x == 5'd17 || x == 5'd18 || x == 5'd20);
      if (k_ok)
         pair4 = TK4[y];
      else if (y == 3'd7 && use_a7)
         pair4 = A7_4B;
      else
         pair4 = T4[y];
      c4     = rd_mid ? pair4[3:0] : pair4[7:4];
      rd_out = rd_mid ^ ($countones(c4) != 2);
      // tables are MSB-first in line order; port wants a/f at the LSB
      symbol = '0;
      for (int i = 0; i < 6; i++)
         symbol[i] = c6[5-i];
      for (int i = 0; i < 4; i++)
         symbol[6+i] = c4[3-i];
   end

endmodule

// File: rtl/enc_8b10b_rd.sv
// enc_8b10b_rd: multi-lane RD-tracking 8b/10b encoder, registered valid/ready out.
// Ports: in_valid/in_ready/data_in/k_in -> out_valid/out_ready/data_out/k_err, rd_out.
module enc_8b10b_rd
   import enc_8b10b_pkg::*;
#(
   parameter int   LANES   = 1,
   parameter logic RD_INIT = 1'b0
)(
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BYTE_W*LANES-1:0] data_in,
   input  logic [LANES-1:0]        k_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SYM_W*LANES-1:0]  data_out,
   output logic [LANES-1:0]        k_err,
   output logic                    rd_out
);

   logic [SYM_W*LANES-1:0] sym_all;
   logic [SYM_W*LANES-1:0] data_d, data_q;
   logic [LANES-1:0]       kerr_all;
   logic [LANES-1:0]       k_err_d, k_err_q;
   logic [LANES:0]         rd_chain;
   logic                   valid_d, valid_q;
   logic                   rd_d, rd_q;
   logic                   accept;

   // lane n starts from the RD left behind by lane n-1
   assign rd_chain[0] = rd_q;

   for (genvar n = 0; n < LANES; n++) begin : g_lane
      enc_8b10b_lane u_lane (
         .byte_in (data_in[BYTE_W*n +: BYTE_W]),
         .k_in    (k_in[n]),
         .rd_in   (rd_chain[n]),
         .symbol  (sym_all[SYM_W*n +: SYM_W]),
         .rd_out  (rd_chain[n+1]),
         .k_err   (kerr_all[n])
      );
   end

   always_comb begin
      in_ready = !valid_q || out_ready;
      accept   = in_valid && in_ready;
      data_d   = data_q;
      k_err_d  = k_err_q;
      rd_d     = rd_q;
      valid_d  = valid_q;
      if (accept) begin
         data_d  = sym_all;
         k_err_d = kerr_all;
         rd_d    = rd_chain[LANES];
         valid_d = 1'b1;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         data_q  <= '0;
         k_err_q <= '0;
         rd_q    <= RD_INIT;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         k_err_q <= k_err_d;
         rd_q    <= rd_d;
         valid_q <= valid_d;
      end
   end

   assign data_out  = data_q;
   assign k_err     = k_err_q;
   assign rd_out    = rd_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_enc_8b10b_rd.sv
// tb_enc_8b10b_rd: golden vectors, handshake corners and random beats
// against a rule-based 8b/10b reference model.
module tb_enc_8b10b_rd;

   logic        clk = 1'b0;
   logic        nrst;
   logic        v1, r1, k1, ov1, or1, rd1, ke1;
   logic [7:0]  d1;
   logic [9:0]  do1;
   logic        v4, r4, ov4, or4, rd4;
   logic [31:0] d4;
   logic [3:0]  k4, ke4;
   logic [39:0] do4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   enc_8b10b_rd #(.LANES(1), .RD_INIT(1'b0)) u1 (
      .CLK(clk), .nRST(nrst), .in_valid(v1), .in_ready(r1),
      .data_in(d1), .k_in(k1), .out_valid(ov1), .out_ready(or1),
      .data_out(do1), .k_err(ke1), .rd_out(rd1)
   );

   enc_8b10b_rd #(.LANES(4), .RD_INIT(1'b1)) u4 (
      .CLK(clk), .nRST(nrst), .in_valid(v4), .in_ready(r4),
      .data_in(d4), .k_in(k4), .out_valid(ov4), .out_ready(or4),
      .data_out(do4), .k_err(ke4), .rd_out(rd4)
   );

   // RD- primary codes; RD+ form is the complement when needed
   localparam logic [5:0] P6 [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
      6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
      6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
      6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
      6'b011110, 6'b101011
   };
   localparam logic [3:0] P4 [8] = '{
      4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
   };
   localparam logic [3:0] PK4 [8] = '{
      4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111
   };
   localparam logic [7:0] KS [12] = '{
      8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
      8'hF7, 8'hFB, 8'hFD, 8'hFE
   };

   // line order "abcdeifghj" -> port order (a at bit 0)
   function automatic logic [9:0] to_port(input logic [9:0] s);
      logic [9:0] r;
      for (int i = 0; i < 10; i++)
         r[i] = s[9-i];
      return r;
   endfunction

   function automatic void ref_lane(input logic [7:0] b, input logic k,
                                    input logic rd, output logic [9:0] sym,
                                    output logic rd_o, output logic kerr);
      logic [4:0] x;
      logic [2:0] y;
      logic       kok, unb6, rdm, inv4;
      logic [5:0] c6;
      logic [3:0] c4;
      x    = b[4:0];
      y    = b[7:5];
      kok  = k && (x == 5'd28 || b inside {8'hF7, 8'hFB, 8'hFD, 8'hFE});
      kerr = k && !kok;
      c6   = (kok && x == 5'd28) ? 6'b001111 : P6[x];
      unb6 = $countones(c6) != 3;
      if (rd && (unb6 || c6 == 6'b111000))
         c6 = ~c6;
      rdm = rd ^ unb6;
      if (kok) begin
         c4   = PK4[y];
         inv4 = 1'b1;
      end else if (y == 3'd7 && (rdm ? (x inside {5'd11, 5'd13, 5'd14})
                                     : (x inside {5'd17, 5'd18, 5'd20}))) begin
         c4   = 4'b0111;
         inv4 = 1'b1;
      end else begin
         c4   = P4[y];
         inv4 = ($countones(c4) != 2) || y == 3'd3;
      end
      if (rdm && inv4)
         c4 = ~c4;
      rd_o = rdm ^ ($countones(c4) != 2);
      sym  = to_port({c6, c4});
   endfunction

   function automatic void ref_beat(input logic [31:0] d, input logic [3:0] k,
                                    input logic rd_i, output logic [39:0] s,
                                    output logic [3:0] ke, output logic rd_o);
      logic       r, lr, lk;
      logic [9:0] ls;
      s  = '0;
      ke = '0;
      r  = rd_i;
      for (int n = 0; n < 4; n++) begin
         ref_lane(d[8*n +: 8], k[n], r, ls, lr, lk);
         s[10*n +: 10] = ls;
         ke[n] = lk;
         r = lr;
      end
      rd_o = r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] b;
      logic       k;
      logic [9:0] sym;
      logic       rd;
      logic       kerr;
   } vec_t;

   vec_t vec [13];

   logic [9:0]  es1, sa1;
   logic        er1, ek1, ra1;
   logic [39:0] es4, mdata;
   logic [3:0]  ek4, mkerr;
   logic        er4, mrd, mv, acc;

   initial begin
      vec[0]  = '{8'hB5, 1'b0, 10'b101010_1010, 1'b0, 1'b0};
      vec[1]  = '{8'hBC, 1'b1, 10'b001111_1010, 1'b1, 1'b0};
      vec[2]  = '{8'hBC, 1'b1, 10'b110000_0101, 1'b0, 1'b0};
      vec[3]  = '{8'hF1, 1'b0, 10'b100011_0111, 1'b1, 1'b0};
      vec[4]  = '{8'hE3, 1'b0, 10'b110001_0001, 1'b0, 1'b0};
      vec[5]  = '{8'h00, 1'b0, 10'b100111_0100, 1'b0, 1'b0};
      vec[6]  = '{8'h00, 1'b1, 10'b100111_0100, 1'b0, 1'b1};
      vec[7]  = '{8'hFE, 1'b1, 10'b011110_1000, 1'b0, 1'b0};
      vec[8]  = '{8'h7C, 1'b1, 10'b001111_0011, 1'b1, 1'b0};
      vec[9]  = '{8'hF8, 1'b0, 10'b001100_1110, 1'b1, 1'b0};
      vec[10] = '{8'hEB, 1'b0, 10'b110100_1000, 1'b0, 1'b0};
      vec[11] = '{8'h07, 1'b0, 10'b111000_1011, 1'b1, 1'b0};
      vec[12] = '{8'h67, 1'b0, 10'b000111_0011, 1'b1, 1'b0};

      nrst = 1'b0;
      v1 = 1'b0; d1 = '0; k1 = 1'b0; or1 = 1'b1;
      v4 = 1'b0; d4 = '0; k4 = '0;   or4 = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ov1", ov1, 1'b0);
      chk("rst_do1", do1, 10'd0);
      chk("rst_ke1", ke1, 1'b0);
      chk("rst_rd1", rd1, 1'b0);
      chk("rst_ov4", ov4, 1'b0);
      chk("rst_do4", do4, 40'd0);
      chk("rst_rd4", rd4, 1'b1);
      nrst = 1'b1;

      // golden single-lane sequence starting at RD-
      for (int i = 0; i < 13; i++) begin
         v1 = 1'b1; d1 = vec[i].b; k1 = vec[i].k;
         @(posedge clk);
         @(negedge clk);
         v1 = 1'b0;
         chk($sformatf("vec%0d_ov", i), ov1, 1'b1);
         chk($sformatf("vec%0d_sym", i), do1, to_port(vec[i].sym));
         chk($sformatf("vec%0d_rd", i), rd1, vec[i].rd);
         chk($sformatf("vec%0d_kerr", i), ke1, vec[i].kerr);
      end

      // drain with no accept: valid drops, data holds
      @(posedge clk);
      @(negedge clk);
      chk("drain_ov", ov1, 1'b0);
      chk("drain_hold", do1, to_port(vec[12].sym));
      chk("drain_rd", rd1, 1'b1);

      // stall: beat A held 5 cycles, beat B waits, then loads with no bubble
      ref_lane(8'h83, 1'b0, 1'b1, sa1, ra1, ek1);
      v1 = 1'b1; d1 = 8'h83; k1 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      or1 = 1'b0; d1 = 8'h90;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("stall_in_ready", r1, 1'b0);
         @(posedge clk);
         @(negedge clk);
         chk("stall_ov", ov1, 1'b1);
         chk("stall_data", do1, sa1);
         chk("stall_rd", rd1, ra1);
      end
      or1 = 1'b1;
      #1;
      chk("release_in_ready", r1, 1'b1);
      ref_lane(8'h90, 1'b0, ra1, es1, er1, ek1);
      @(posedge clk);
      @(negedge clk);
      v1 = 1'b0;
      chk("release_ov", ov1, 1'b1);
      chk("release_data", do1, es1);
      chk("release_rd", rd1, er1);
      @(posedge clk);
      @(negedge clk);
      chk("release_single", ov1, 1'b0);

      // unsupported K then reset while a beat is held
      ref_lane(8'h00, 1'b1, er1, es1, ra1, ek1);
      v1 = 1'b1; d1 = 8'h00; k1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("badk_kerr", ke1, 1'b1);
      chk("badk_sym", do1, es1);
      chk("badk_rd", rd1, ra1);
      d1 = 8'hBC;
      nrst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      nrst = 1'b1; v1 = 1'b0; k1 = 1'b0;
      chk("midrst_ov", ov1, 1'b0);
      chk("midrst_rd", rd1, 1'b0);
      chk("midrst_do", do1, 10'd0);
      chk("midrst_ke", ke1, 1'b0);
      chk("midrst_rd4", rd4, 1'b1);

      // four-lane beat from RD+
      v4 = 1'b1; d4 = {8'hBC, 8'hB5, 8'h00, 8'hBC}; k4 = 4'b1001;
      ref_beat(d4, k4, 1'b1, es4, ek4, er4);
      @(posedge clk);
      @(negedge clk);
      v4 = 1'b0;
      chk("lane4_gold", do4, {to_port(10'b001111_1010), to_port(10'b101010_1010),
                              to_port(10'b100111_0100), to_port(10'b110000_0101)});
      chk("lane4_model", do4, es4);
      chk("lane4_rd", rd4, 1'b1);
      chk("lane4_rd_model", rd4, er4);
      chk("lane4_kerr", ke4, 4'b0000);

      // random beats with random backpressure
      mv = 1'b1; mdata = es4; mkerr = ek4; mrd = er4;
      for (int c = 0; c < 400; c++) begin
         v4  = ($urandom_range(0, 3) != 0);
         or4 = ($urandom_range(0, 9) < 7);
         for (int n = 0; n < 4; n++) begin
            k4[n] = ($urandom_range(0, 3) == 0);
            if (k4[n] && $urandom_range(0, 3) != 0)
               d4[8*n +: 8] = KS[$urandom_range(0, 11)];
            else
               d4[8*n +: 8] = 8'($urandom_range(0, 255));
         end
         #1;
         chk("rnd_in_ready", r4, !mv || or4);
         acc = v4 && (!mv || or4);
         if (acc) begin
            ref_beat(d4, k4, mrd, es4, ek4, er4);
            mdata = es4; mkerr = ek4; mrd = er4; mv = 1'b1;
         end else if (or4) begin
            mv = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         chk("rnd_ov", ov4, mv);
         chk("rnd_data", do4, mdata);
         chk("rnd_kerr", ke4, mkerr);
         chk("rnd_rd", rd4, mrd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/enc_8b10b_rd.md
Name: enc_8b10b_rd

Overview:
Multi-lane, disparity-tracking 8b/10b encoder with K-character support and a valid/ready registered output stage. It replaces the earlier table-only encoder, which had no running disparity, no control symbols and no flow control. It sits between the link-layer framer (upstream) and the serializer/PHY (downstream). Each cycle it encodes LANES bytes as one ordered symbol group.

Parameters:
LANES, 1, number of bytes encoded per accepted beat. Lane 0 is transmitted first. Legal range is 1..8.
RD_INIT, 0, running disparity after reset: 0 = RD-, 1 = RD+.

Ports:
CLK  input  1  clock
nRST  input  1  reset, synchronous, active-low
in_valid  input  1  upstream beat valid
in_ready  output  1  encoder can accept a beat this cycle
data_in  input  8*LANES  byte per lane; lane n = [8n+7:8n], bits HGFEDCBA
k_in  input  LANES  1 = lane byte is a control (K) character
out_valid  output  1  data_out holds an encoded beat
out_ready  input  1  downstream accepts the beat
data_out  output  10*LANES  symbol per lane; lane n = [10n+9:10n]; [5:0] = abcdei (a = bit 0), [9:6] = fghj (f = bit 6)
k_err  output  LANES  lane requested an unsupported K code (registered with data_out)
rd_out  output  1  current running disparity, 1 = RD+ (after last accepted beat)

Behaviour:
- Reset (nRST = 0 at a CLK edge):
  - out_valid = 0, data_out = 0, k_err = 0.
  - rd_out = RD_INIT.
  - Any held beat is discarded. Reset has priority over every other event.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A beat is accepted when in_valid && in_ready.
  - Latency is 1 cycle: the accepted beat appears on data_out the next cycle with out_valid = 1.
  - While out_valid && !out_ready: data_out, k_err and rd_out hold stable, and in_ready = 0.
  - A simultaneous drain and accept loads the new beat. out_valid stays 1, with no bubble.
  - No accept with a drain: out_valid falls to 0 and data_out holds its last value.
- Disparity chain (combinational within a beat):
  - Lane 0 uses the registered RD.
  - Lane n uses the RD produced by lane n-1.
  - The RD out of lane LANES-1 is registered into rd_out on accept only.
- Per-lane encoding, 5b/6b on EDCBA, then 3b/4b on HGF using the RD after the 6b sub-block:
  - An unbalanced sub-block (disparity ±2) uses the RD- or RD+ alternate and flips RD.
  - A balanced sub-block leaves RD unchanged.
  - D.7 (111000 at RD-, 000111 at RD+) and x.3 (1100 at RD-, 0011 at RD+) are balanced but RD-selected.
  - D.x.7 uses A7 (0111 at RD-, 1000 at RD+) when RD- and x ∈ {17, 18, 20}, or RD+ and x ∈ {11, 13, 14}. Otherwise it uses P7 (1110 at RD-, 0001 at RD+).
- K characters: supported codes are K28.0–K28.7, K23.7, K27.7, K29.7 and K30.7.
  - K28 6b sub-block = 001111 at RD-, 110000 at RD+.
  - K.x.7 always uses the A7 form.
  - K28.1/.5/.6 use inverted-balance fghj per the standard table.
- Unsupported K (k_in = 1 with any other byte): the lane is encoded as the D character of the same byte, its k_err bit = 1, and RD is updated from the emitted symbol.
- Outputs update only on an accept or reset edge.

Decomposition:
- Package enc_8b10b_pkg holds:
  - 5b/6b table, 32 entries of {RD- code, RD+ code}.
  - 3b/4b data table, 8 entries, including the P7/A7 pair.
  - K 3b/4b table.
  - Supported-K lookup function.
  - Lane width constants (8, 10).
- Sub-module enc_8b10b_lane: purely combinational. Inputs are byte, k, rd_in. Outputs are symbol[9:0], rd_out, k_err.
- The top generates LANES instances, chains their RD, and owns the output register and handshake.

Test Plan:
1. Reset with RD_INIT=0, LANES=1; send D.21.5 (0xB5) -> data_out abcdei=101010, fghj=1010; rd_out stays 0; out_valid=1 one cycle after accept.
2. Send K28.5 (0xBC, k=1) twice at RD- -> first 001111_1010 (rd_out=1), second 110000_0101 (rd_out=0).
3. D.17.7 (0xF1) at RD- -> 100011_0111 (A7), rd_out=1. Then D.3.7 (0xE3) at RD+ -> 110001_0001 (P7), rd_out=0. D.0.0 at RD- -> 100111_0100, rd_out=0.
4. LANES=4, in one beat {K28.5, D.0.0, D.21.5, K28.5} -> lane RDs chain correctly; rd_out = XOR of lane flips; every lane matches the serialized single-lane golden model.
5. Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, data_out and rd_out stable. Release -> next beat loads the same cycle with no bubble and no lost or duplicated beat.
6. k_in=1 with 0x00 (unsupported) -> k_err=1, symbol = D.0.0 encoding. Assert nRST=0 mid-stream while out_valid=1 -> next cycle out_valid=0, rd_out=RD_INIT.
